// File: rtl/pmod_dac_pkg.sv
// Shared definitions for the PMOD DAC serializers: FSM encodings and frame layout.
// Also imported by the CORDIC tops so that every DAC frame is built the same way.
package pmod_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } dac_state_e;

    // Power-down/mode field sits directly above the sample
    localparam int PD_FIELD_W = 2;

    function automatic int pd_lsb(input int width);
        return width;
    endfunction

endpackage

// File: rtl/pmod_sclk_div.sv
// Divide-by-CLK_DIV tick generator for the serial clock, with synchronous clear.
// Tick marks a terminal count; rise/fall qualify it by the current sclk level.
module pmod_sclk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic sclk_level,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt_r;

    // Divider counter, reloaded explicitly at terminal count
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DW'(1);
        end
    end

    // Strobe decode; a tick while sclk is high is a falling edge
    always_comb begin
        tick = !clear && (cnt_r == LAST);
        rise = tick && !sclk_level;
        fall = tick && sclk_level;
    end

endmodule

// File: rtl/pmod_dac_multich.sv
// Multi-lane SPI serializer for PMOD DACs: one handshake accepts a sample per channel,
// then all lanes shift {zeros, PD_BITS, sample} MSB-first under a shared cs/sclk.
module pmod_dac_multich
    import pmod_dac_pkg::*;
#(
    parameter int         WIDTH      = 12,
    parameter int         CH         = 2,
    parameter int         FRAME_BITS = 16,
    parameter int         CLK_DIV    = 2,
    parameter int         CS_IDLE    = 1,
    parameter int         SIGNED_IN  = 1,
    parameter logic [1:0] PD_BITS    = 2'b00
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CH*WIDTH-1:0]   s_data,
    output logic                  cs,
    output logic                  sclk,
    output logic [CH-1:0]         data,
    output logic                  done
);

    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(2 * CS_IDLE + 1);
    localparam int PD_LSB = pd_lsb(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS);
    localparam logic [GW-1:0] GAP_END  = GW'(2 * CS_IDLE - 1);
    // Two's complement to offset binary is just an MSB flip
    localparam logic [WIDTH-1:0] SIGN_MASK = (SIGNED_IN != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    dac_state_e    state_r, state_nxt;
    logic          cs_r, cs_nxt, sclk_r, sclk_nxt, done_r, done_nxt, ready_r, ready_nxt;
    logic [BW-1:0] bit_cnt_r, bit_cnt_nxt;
    logic [GW-1:0] gap_cnt_r, gap_cnt_nxt;
    logic          load_s, shift_s, clear_data_s;
    logic          tick_s, rise_s, fall_s;

    pmod_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (state_r == IDLE),
        .sclk_level (sclk_r),
        .tick       (tick_s),
        .rise       (rise_s),
        .fall       (fall_s)
    );

    // Next-state, framing and handshake decode
    always_comb begin
        state_nxt    = state_r;
        cs_nxt       = cs_r;
        sclk_nxt     = sclk_r;
        done_nxt     = 1'b0;
        ready_nxt    = 1'b0;
        bit_cnt_nxt  = bit_cnt_r;
        gap_cnt_nxt  = gap_cnt_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        clear_data_s = 1'b0;
        case (state_r)
            IDLE: begin
                cs_nxt      = 1'b1;
                sclk_nxt    = 1'b1;
                bit_cnt_nxt = '0;
                if (s_valid && ready_r) begin
                    load_s    = 1'b1;
                    cs_nxt    = 1'b0;
                    state_nxt = SHIFT;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (fall_s) begin
                    sclk_nxt    = 1'b0;
                    bit_cnt_nxt = bit_cnt_r + BW'(1);
                end else if (rise_s) begin
                    sclk_nxt = 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        cs_nxt       = 1'b1;
                        done_nxt     = 1'b1;
                        clear_data_s = 1'b1;
                        gap_cnt_nxt  = '0;
                        state_nxt    = GAP;
                    end else begin
                        shift_s = 1'b1;
                    end
                end else begin
                    sclk_nxt = sclk_r;
                end
            end
            GAP: begin
                if (tick_s) begin
                    if (gap_cnt_r == GAP_END) begin
                        gap_cnt_nxt = '0;
                        ready_nxt   = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        gap_cnt_nxt = gap_cnt_r + GW'(1);
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt_r;
                end
            end
            default: begin
                cs_nxt    = 1'b1;
                sclk_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r   <= IDLE;
            cs_r      <= 1'b1;
            sclk_r    <= 1'b1;
            done_r    <= 1'b0;
            ready_r   <= 1'b0;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt;
            cs_r      <= cs_nxt;
            sclk_r    <= sclk_nxt;
            done_r    <= done_nxt;
            ready_r   <= ready_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            gap_cnt_r <= gap_cnt_nxt;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic [WIDTH-1:0]      sample_s;
        logic [FRAME_BITS-1:0] frame_s, shreg_r;
        logic                  bit_r;

        assign sample_s = s_data[k*WIDTH +: WIDTH] ^ SIGN_MASK;

        // Frame assembly: zeros above the mode field
        always_comb begin
            frame_s                            = '0;
            frame_s[WIDTH-1:0]                 = sample_s;
            frame_s[PD_LSB +: PD_FIELD_W]      = PD_BITS;
        end

        // Lane shift register; the output bit always mirrors the next MSB
        always_ff @(posedge clock) begin
            if (!resetn) begin
                shreg_r <= '0;
                bit_r   <= 1'b0;
            end else if (load_s) begin
                shreg_r <= frame_s;
                bit_r   <= frame_s[FRAME_BITS-1];
            end else if (shift_s) begin
                shreg_r <= {shreg_r[FRAME_BITS-2:0], 1'b0};
                bit_r   <= shreg_r[FRAME_BITS-2];
            end else if (clear_data_s) begin
                bit_r   <= 1'b0;
            end else begin
                shreg_r <= shreg_r;
                bit_r   <= bit_r;
            end
        end

        assign data[k] = bit_r;
    end

    assign cs      = cs_r;
    assign sclk    = sclk_r;
    assign done    = done_r;
    assign s_ready = ready_r;

endmodule

// File: tb/tb_pmod_dac_multich.sv
// Directed bench for pmod_dac_multich: three parameterisations, pin-level monitors that
// capture each lane on sclk falling edges, and hand-computed expected frames.
module tb_pmod_dac_multich;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // A: signed 12-bit, 2 lanes, CLK_DIV=2
    logic va, ra, csa, sclka, donea;
    logic [23:0] da;
    logic [1:0]  qa;
    // B: unsigned 12-bit, PD=11
    logic vb, rb, csb, sclkb, doneb;
    logic [23:0] db;
    logic [1:0]  qb;
    // C: signed 8-bit, 4 lanes, CLK_DIV=1
    logic vc, rc, csc, sclkc, donec;
    logic [31:0] dc;
    logic [3:0]  qc;

    pmod_dac_multich #(.WIDTH(12), .CH(2), .FRAME_BITS(16), .CLK_DIV(2), .CS_IDLE(1),
                       .SIGNED_IN(1), .PD_BITS(2'b00)) dut_a (
        .clock(clock), .resetn(resetn), .s_valid(va), .s_ready(ra), .s_data(da),
        .cs(csa), .sclk(sclka), .data(qa), .done(donea));
    pmod_dac_multich #(.WIDTH(12), .CH(2), .FRAME_BITS(16), .CLK_DIV(2), .CS_IDLE(1),
                       .SIGNED_IN(0), .PD_BITS(2'b11)) dut_b (
        .clock(clock), .resetn(resetn), .s_valid(vb), .s_ready(rb), .s_data(db),
        .cs(csb), .sclk(sclkb), .data(qb), .done(doneb));
    pmod_dac_multich #(.WIDTH(8), .CH(4), .FRAME_BITS(16), .CLK_DIV(1), .CS_IDLE(1),
                       .SIGNED_IN(1), .PD_BITS(2'b00)) dut_c (
        .clock(clock), .resetn(resetn), .s_valid(vc), .s_ready(rc), .s_data(dc),
        .cs(csc), .sclk(sclkc), .data(qc), .done(donec));

    int falls_a = 0, cslow_a = 0, dones_a = 0, readys_a = 0, gap_run_a = 0, last_gap_a = 0;
    int falls_b = 0, cslow_b = 0, dones_b = 0;
    int falls_c = 0, cslow_c = 0, dones_c = 0;
    logic prev_a = 1'b1, prev_b = 1'b1, prev_c = 1'b1;
    logic [47:0] cap_a [2];
    logic [15:0] cap_b [2];
    logic [15:0] cap_c [4];

    // Monitor A: what the DAC would latch, plus cs/gap/handshake statistics
    always @(negedge clock) begin
        prev_a <= sclka;
        if (csa == 1'b0 && prev_a == 1'b1 && sclka == 1'b0) begin
            falls_a <= falls_a + 1;
            for (int k = 0; k < 2; k++) cap_a[k] <= {cap_a[k][46:0], qa[k]};
        end
        if (csa == 1'b0) cslow_a <= cslow_a + 1;
        if (donea == 1'b1) dones_a <= dones_a + 1;
        if (ra == 1'b1) readys_a <= readys_a + 1;
        if (csa == 1'b1) begin
            gap_run_a <= gap_run_a + 1;
        end else begin
            if (gap_run_a != 0) last_gap_a <= gap_run_a;
            gap_run_a <= 0;
        end
    end

    // Monitor B
    always @(negedge clock) begin
        prev_b <= sclkb;
        if (csb == 1'b0 && prev_b == 1'b1 && sclkb == 1'b0) begin
            falls_b <= falls_b + 1;
            for (int k = 0; k < 2; k++) cap_b[k] <= {cap_b[k][14:0], qb[k]};
        end
        if (csb == 1'b0) cslow_b <= cslow_b + 1;
        if (doneb == 1'b1) dones_b <= dones_b + 1;
    end

    // Monitor C
    always @(negedge clock) begin
        prev_c <= sclkc;
        if (csc == 1'b0 && prev_c == 1'b1 && sclkc == 1'b0) begin
            falls_c <= falls_c + 1;
            for (int k = 0; k < 4; k++) cap_c[k] <= {cap_c[k][14:0], qc[k]};
        end
        if (csc == 1'b0) cslow_c <= cslow_c + 1;
        if (donec == 1'b1) dones_c <= dones_c + 1;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_of(input int w);
        case (w)
            0:       return ra;
            1:       return rb;
            default: return rc;
        endcase
    endfunction

    function automatic int dones_of(input int w);
        case (w)
            0:       return dones_a;
            1:       return dones_b;
            default: return dones_c;
        endcase
    endfunction

    task automatic wait_ready(input int w);
        int n = 0;
        while (ready_of(w) !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check_eq("ready_wait", ready_of(w), 1'b1);
    endtask

    task automatic wait_done(input int w, input int target);
        int n = 0;
        while (dones_of(w) < target && n < 400) begin
            tick();
            n++;
        end
        check_eq("done_wait", dones_of(w), target);
    endtask

    int bf, bl, bd, br, n;
    logic [23:0] bundles [3];

    initial begin
        resetn = 1'b0;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        da = '0; db = '0; dc = '0;
        bundles[0] = {12'hFFF, 12'h000};
        bundles[1] = {12'h3C3, 12'h5A5};
        bundles[2] = {12'h0FE, 12'h801};

        // 1. reset levels, then s_ready on the first edge after release
        repeat (5) tick();
        check_eq("rst_cs", csa, 1'b1);
        check_eq("rst_sclk", sclka, 1'b1);
        check_eq("rst_data", qa, 2'b00);
        check_eq("rst_ready", ra, 1'b0);
        check_eq("rst_done", donea, 1'b0);
        check_eq("rst_cs_c", csc, 1'b1);
        resetn = 1'b1;
        tick();
        check_eq("rel_ready", ra, 1'b1);

        // 2. signed conversion: 7FF -> FFF, 800 -> 000
        bf = falls_a; bl = cslow_a; bd = dones_a;
        wait_ready(0);
        da = {12'h800, 12'h7FF}; va = 1'b1;
        tick();
        va = 1'b0;
        wait_done(0, bd + 1);
        repeat (3) tick();
        check_eq("t2_lane0", cap_a[0][15:0], 16'h0FFF);
        check_eq("t2_lane1", cap_a[1][15:0], 16'h0000);
        check_eq("t2_falls", falls_a - bf, 16);
        check_eq("t2_cslow", cslow_a - bl, 64);
        check_eq("t2_dones", dones_a - bd, 1);

        // 3. unsigned with PD field 11
        bf = falls_b; bd = dones_b;
        wait_ready(1);
        db = {12'hABC, 12'h123}; vb = 1'b1;
        tick();
        vb = 1'b0;
        wait_done(1, bd + 1);
        tick();
        check_eq("t3_lane0", cap_b[0], 16'h3123);
        check_eq("t3_lane1", cap_b[1], 16'h3ABC);
        check_eq("t3_falls", falls_b - bf, 16);

        // 4. s_valid held high across three bundles
        bd = dones_a;
        for (int i = 0; i < 3; i++) begin
            wait_ready(0);
            da = bundles[i]; va = 1'b1;
            tick();
            if (i == 0) br = readys_a;
            if (i > 0) begin
                tick();
                check_eq("t4_gap", last_gap_a, 5);
            end
        end
        check_eq("t4_ready_cycles", readys_a - br, 2);
        va = 1'b0;
        wait_done(0, bd + 3);
        tick();
        check_eq("t4_lane0", cap_a[0], 48'h0800_0DA5_0001);
        check_eq("t4_lane1", cap_a[1], 48'h07FF_0BC3_08FE);

        // 5. reset right after the 7th falling edge aborts the frame
        bf = falls_a; bd = dones_a;
        wait_ready(0);
        da = {12'h222, 12'h111}; va = 1'b1;
        tick();
        va = 1'b0;
        n = 0;
        while ((falls_a - bf) < 7 && n < 200) begin
            tick();
            n++;
        end
        check_eq("t5_fall7", falls_a - bf, 7);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_eq("t5_cs", csa, 1'b1);
        check_eq("t5_sclk", sclka, 1'b1);
        check_eq("t5_data", qa, 2'b00);
        check_eq("t5_ready", ra, 1'b0);
        tick();
        check_eq("t5_ready_rel", ra, 1'b1);
        tick();
        check_eq("t5_no_done", dones_a - bd, 0);
        bf = falls_a; bl = cslow_a;
        wait_ready(0);
        da = {12'h9CD, 12'h7AB}; va = 1'b1;
        tick();
        va = 1'b0;
        wait_done(0, bd + 1);
        tick();
        check_eq("t5_lane0", cap_a[0][15:0], 16'h0FAB);
        check_eq("t5_lane1", cap_a[1][15:0], 16'h01CD);
        check_eq("t5_falls", falls_a - bf, 16);
        check_eq("t5_cslow", cslow_a - bl, 64);

        // 6. CLK_DIV=1, four 8-bit lanes
        bf = falls_c; bl = cslow_c; bd = dones_c;
        wait_ready(2);
        dc = {8'hA5, 8'h80, 8'h7F, 8'h00}; vc = 1'b1;
        tick();
        vc = 1'b0;
        wait_done(2, bd + 1);
        repeat (2) tick();
        check_eq("t6_lane0", cap_c[0], 16'h0080);
        check_eq("t6_lane1", cap_c[1], 16'h00FF);
        check_eq("t6_lane2", cap_c[2], 16'h0000);
        check_eq("t6_lane3", cap_c[3], 16'h0025);
        check_eq("t6_falls", falls_c - bf, 16);
        check_eq("t6_cslow", cslow_c - bl, 32);
        check_eq("t6_dones", dones_c - bd, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
